// File: rtl/core_run_controller.sv
// Run/pause/step/breakpoint scheduler for the RV32I core, plus 7-segment source sequencing.
// Everything lives in the clk domain; the switch and button are synchronized and the button debounced.
module core_run_controller #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DISP_HOLD       = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_in,
  input  logic [1:0]  disp_mode,
  output logic        core_en,
  output logic        halted,
  output logic [31:0] step_count,
  output logic [31:0] seg_data,
  output logic        seg_sel
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   presc_reg, presc_next;
  logic            core_en_next;
  logic [1:0]      run_sync, step_sync;
  logic            run_s, step_s;
  logic            db_level, step_press;
  logic [DW-1:0]   db_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            page;

  assign run_s  = run_sync[1];
  assign step_s = step_sync[1];
  assign halted = (state_reg == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_sync  <= 2'b00;
      step_sync <= 2'b00;
    end else begin
      run_sync  <= {run_sync[0], run_sw};
      step_sync <= {step_sync[0], step_btn};
    end
  end

  // Any sample agreeing with the current level restarts the stability count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_level   <= 1'b0;
      db_cnt     <= '0;
      step_press <= 1'b0;
    end else begin
      step_press <= 1'b0;
      if (step_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_level   <= step_s;
        db_cnt     <= '0;
        step_press <= step_s;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    presc_next   = '0;
    core_en_next = 1'b0;
    case (state_reg)
      PAUSE: begin
        if (step_press) begin
          state_next   = STEP;
          core_en_next = 1'b1;
        end else if (run_s) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Dropping the switch wins over a terminal count in the same cycle.
        if (!run_s) begin
          state_next = PAUSE;
        end else if (presc_reg == TW'(TICK_DIV - 1)) begin
          if (bp_en && (pc_in == bp_addr)) state_next = HALT;
          else core_en_next = 1'b1;
        end else begin
          presc_next = presc_reg + TW'(1);
        end
      end
      STEP: state_next = PAUSE;
      HALT: begin
        if (step_press) begin
          state_next   = STEP;
          core_en_next = 1'b1;
        end else if (!run_s) begin
          state_next = PAUSE;
        end
      end
      default: state_next = PAUSE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= PAUSE;
      presc_reg  <= '0;
      core_en    <= 1'b0;
      step_count <= '0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      core_en    <= core_en_next;
      step_count <= step_count + {31'b0, core_en};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      page     <= 1'b0;
    end else if (hold_cnt == HW'(DISP_HOLD - 1)) begin
      hold_cnt <= '0;
      page     <= ~page;
    end else begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_data <= '0;
      seg_sel  <= 1'b0;
    end else begin
      case (disp_mode)
        2'b00: begin seg_data <= pc_in;  seg_sel <= 1'b0; end
        2'b01: begin seg_data <= alu_in; seg_sel <= 1'b1; end
        2'b10: begin seg_data <= page ? alu_in : pc_in; seg_sel <= page; end
        default: begin
          seg_data <= {2'b00, state_reg, 12'h000, step_count[15:0]};
          seg_sel  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_controller.sv
// Scoreboard bench for core_run_controller: a timeline-based reference model predicts
// every output each cycle; a negedge monitor pops and compares.
module tb_core_run_controller;
  localparam int T    = 4;
  localparam int DEB  = 3;
  localparam int D    = 5;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_sw = 1'b0, step_btn = 1'b0, bp_en = 1'b0;
  logic [31:0] bp_addr = '0, pc_in = '0, alu_in = '0;
  logic [1:0]  disp_mode = 2'b00;
  logic        core_en, halted, seg_sel;
  logic [31:0] step_count, seg_data;

  always #5 clk = ~clk;

  core_run_controller #(.TICK_DIV(T), .DEBOUNCE_CYCLES(DEB), .DISP_HOLD(D)) dut (
    .clk(clk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc_in(pc_in), .alu_in(alu_in), .disp_mode(disp_mode),
    .core_en(core_en), .halted(halted), .step_count(step_count),
    .seg_data(seg_data), .seg_sel(seg_sel)
  );

  typedef struct packed {
    logic        ce;
    logic        hl;
    logic [31:0] cnt;
    logic [31:0] seg;
    logic        sel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, passed = 0, pulses = 0;
  bit   mon_en = 1'b0, in_reset = 1'b1, prev_ce = 1'b0;

  // Model state: values the DUT should present after edge n (edge 0 = reset release).
  int          n, m_state, m_e;
  bit          m_ce, m_press, m_level, m_sel;
  logic [31:0] m_cnt, m_seg;
  bit          hist_run[MAXC], hist_btn[MAXC];

  function automatic bit run_at(int i);
    return (i < 0) ? 1'b0 : hist_run[i % MAXC];
  endfunction

  function automatic bit btn_at(int i);
    return (i < 0) ? 1'b0 : hist_btn[i % MAXC];
  endfunction

  task automatic model_reset();
    n = 0; m_state = 0; m_e = 0;
    m_ce = 0; m_press = 0; m_level = 0; m_sel = 0;
    m_cnt = '0; m_seg = '0;
  endtask

  // Advance the model across one clock edge using the inputs held during the previous cycle.
  task automatic model_edge();
    bit r, all_diff, tc, nce, nsel, page;
    int ns;
    logic [31:0] nseg;
    n++;
    hist_run[(n-1) % MAXC] = run_sw;
    hist_btn[(n-1) % MAXC] = step_btn;
    r = run_at(n - 3);
    all_diff = 1'b1;
    for (int k = 0; k < DEB; k++)
      if (btn_at(n - 3 - k) == m_level) all_diff = 1'b0;
    tc  = ((n - 1 - m_e) % T) == T - 1;
    ns  = m_state;
    nce = 1'b0;
    case (m_state)
      0: if (m_press) begin ns = 2; nce = 1'b1; end
         else if (r) begin ns = 1; m_e = n; end
      1: if (!r) ns = 0;
         else if (tc) begin
           if (bp_en && pc_in == bp_addr) ns = 3; else nce = 1'b1;
         end
      2: ns = 0;
      default: if (m_press) begin ns = 2; nce = 1'b1; end
               else if (!r) ns = 0;
    endcase
    page = ((((n - 1) / D) % 2) == 1);
    case (disp_mode)
      2'b00: begin nseg = pc_in; nsel = 1'b0; end
      2'b01: begin nseg = alu_in; nsel = 1'b1; end
      2'b10: begin nseg = page ? alu_in : pc_in; nsel = page; end
      default: begin nseg = (32'(m_state) << 28) | (m_cnt & 32'h0000FFFF); nsel = 1'b0; end
    endcase
    m_cnt   = m_cnt + (m_ce ? 32'd1 : 32'd0);
    m_press = all_diff && !m_level;
    if (all_diff) m_level = !m_level;
    m_state = ns; m_ce = nce; m_seg = nseg; m_sel = nsel;
  endtask

  task automatic push_exp();
    exp_q.push_back('{m_ce, (m_state == 3), m_cnt, m_seg, m_sel});
    mon_en = 1'b1;
  endtask

  task automatic tick();
    bit old_ce;
    @(posedge clk); #1;
    if (!in_reset) begin
      old_ce = m_ce;
      model_edge();
      if (old_ce) pc_in = pc_in + 32'd4;
    end
    push_exp();
  endtask

  task automatic do_reset(int cyc);
    @(posedge clk); #1;
    reset = 1'b0; in_reset = 1'b1; model_reset(); push_exp();
    repeat (cyc) tick();
    @(posedge clk); #1;
    reset = 1'b1; in_reset = 1'b0; model_reset(); push_exp();
  endtask

  task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    else passed++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL queue_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = exp_q.pop_front();
        check1("core_en",    {31'b0, core_en}, {31'b0, e.ce});
        check1("halted",     {31'b0, halted},  {31'b0, e.hl});
        check1("step_count", step_count,       e.cnt);
        check1("seg_data",   seg_data,         e.seg);
        check1("seg_sel",    {31'b0, seg_sel}, {31'b0, e.sel});
      end
      check1("no_back_to_back", {31'b0, core_en & prev_ce}, 32'd0);
      prev_ce = core_en;
      if (core_en) begin
        pulses++;
        $display("pulse %0d at %0t: step_count=%0d pc_in=%h", pulses, $time, step_count, pc_in);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat[12] = '{1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 0};
    int guard;
    model_reset();
    #1 reset = 1'b0;
    repeat (2) tick();
    @(posedge clk); #1;
    reset = 1'b1; in_reset = 1'b0; model_reset(); push_exp();

    // Free run, then pause.
    run_sw = 1'b1; repeat (20) tick();
    run_sw = 1'b0; repeat (10) tick();

    // Short press, clean press, bouncy press.
    step_btn = 1'b1; repeat (2) tick();
    step_btn = 1'b0; repeat (8) tick();
    step_btn = 1'b1; repeat (6) tick();
    step_btn = 1'b0; repeat (10) tick();
    foreach (pat[i]) begin step_btn = pat[i]; tick(); end
    step_btn = 1'b0; repeat (10) tick();

    // Breakpoint halt, status page, step past it.
    pc_in = 32'h0; bp_addr = 32'h10; bp_en = 1'b1; disp_mode = 2'b11;
    run_sw = 1'b1; repeat (30) tick();
    step_btn = 1'b1; repeat (6) tick();
    step_btn = 1'b0; repeat (14) tick();
    run_sw = 1'b0; bp_en = 1'b0; repeat (6) tick();

    // Display paging and the fixed source modes.
    disp_mode = 2'b10; pc_in = 32'h1234; alu_in = 32'hBEEF; repeat (20) tick();
    disp_mode = 2'b00; repeat (3) tick();
    disp_mode = 2'b01; repeat (3) tick();

    // Reset one cycle ahead of a terminal count.
    run_sw = 1'b1; guard = 0;
    while (!(m_state == 1 && ((n - m_e) % T) == T - 2) && guard < 60) begin tick(); guard++; end
    checks++;
    if (guard >= 60) $display("FAIL reach_run_phase: got %0d cycles expected under 60", guard);
    else passed++;
    do_reset(2);
    repeat (12) tick();
    run_sw = 1'b0; repeat (6) tick();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset(1);
      if ($urandom_range(0, 39) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 4) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 14) == 0) disp_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        bp_en = ~bp_en;
        bp_addr = pc_in + 32'd4 * 32'($urandom_range(0, 3));
      end
      alu_in = $urandom;
      tick();
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
